// File: rtl/task_packer_pkg.sv
// Shared types and sizing helpers for the task answer packer.
package task_packer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } lat_state_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    function automatic int calc_lpw(input int out_width, input int data_width);
        return out_width / data_width;
    endfunction

    function automatic int calc_beat_bytes(input int streams, input int data_width);
        return streams * data_width / 8;
    endfunction

endpackage

// File: rtl/task_beat_fifo.sv
// Synchronous beat FIFO with full/empty flags; a write into a full FIFO is
// accepted when a read happens in the same cycle.
module task_beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/task_answer_packer.sv
// Answer path: buffers multi-lane beats, serializes lanes and packs them into
// OUT_WIDTH words with keep/last, plus byte count, latency and overflow tracking.
module task_answer_packer
    import task_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STREAMS    = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int LAT_WIDTH  = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clear,
    input  logic                          i_in_valid,
    input  logic [STREAMS*DATA_WIDTH-1:0] i_data,
    input  logic                          i_valid,
    input  logic                          i_last,
    output logic [OUT_WIDTH-1:0]          o_data,
    output logic [OUT_WIDTH/8-1:0]        o_keep,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_last,
    output logic [31:0]                   o_size_bytes,
    output logic [LAT_WIDTH-1:0]          o_latency,
    output logic                          o_overflow,
    output logic                          o_busy
);
    localparam int LPW        = calc_lpw(OUT_WIDTH, DATA_WIDTH);
    localparam int BEAT_W     = STREAMS * DATA_WIDTH;
    localparam int KEEP_W     = OUT_WIDTH / 8;
    localparam int LANE_BYTES = DATA_WIDTH / 8;
    localparam int LANE_W     = (STREAMS > 1) ? $clog2(STREAMS) : 1;
    localparam int FILL_W     = (LPW > 1) ? $clog2(LPW) : 1;
    localparam logic [31:0] BEAT_BYTES = 32'(calc_beat_bytes(STREAMS, DATA_WIDTH));

    logic              w_fifo_rd, w_fifo_full, w_fifo_empty, w_drop, w_accept;
    logic [BEAT_W:0]   w_fifo_rdata;
    ser_state_t        r_ser_state, w_ser_next;
    logic [LANE_W-1:0] r_lane, w_lane_next;
    logic [BEAT_W-1:0] r_beat;
    logic              r_beat_last;
    logic [DATA_WIDTH-1:0] w_lane_data;
    logic              w_lane_final, w_flush, w_word_done, w_stall, w_emit;
    logic [OUT_WIDTH-1:0] r_acc, w_word;
    logic [FILL_W-1:0] r_fill;
    logic [KEEP_W-1:0] w_keep;
    logic              r_out_valid, r_out_last;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic [KEEP_W-1:0] r_out_keep;
    logic [31:0]       r_size;
    logic              r_after_last, r_overflow;
    lat_state_t        r_lat_state, w_lat_next;
    logic [LAT_WIDTH-1:0] r_lat_cnt, r_latency, w_cnt_inc;

    task_beat_fifo #(.WIDTH(BEAT_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (i_valid),
        .i_wdata ({i_last, i_data}),
        .i_rd    (w_fifo_rd),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // A full FIFO still takes the beat when the serializer pops in the same cycle.
    assign w_drop   = i_valid && w_fifo_full && !w_fifo_rd;
    assign w_accept = i_valid && !w_drop;

    assign w_lane_data  = r_beat[r_lane*DATA_WIDTH +: DATA_WIDTH];
    assign w_lane_final = (r_lane == LANE_W'(STREAMS - 1));
    assign w_flush      = w_lane_final && r_beat_last;
    assign w_word_done  = (r_fill == FILL_W'(LPW - 1)) || w_flush;
    // Valid/ready: o_valid never depends on i_ready in the same cycle; a word
    // transfers when o_valid && i_ready and is held unchanged otherwise.
    assign w_stall      = w_word_done && r_out_valid && !i_ready;
    assign w_emit       = (r_ser_state == S_SHIFT) && !w_stall;

    always_comb begin
        w_ser_next  = r_ser_state;
        w_lane_next = r_lane;
        w_fifo_rd   = 1'b0;
        case (r_ser_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_fifo_rd   = 1'b1;
                    w_ser_next  = S_SHIFT;
                    w_lane_next = '0;
                end
            end
            S_SHIFT: begin
                if (!w_stall) begin
                    if (w_lane_final) begin
                        w_lane_next = '0;
                        if (!w_fifo_empty) w_fifo_rd  = 1'b1;
                        else               w_ser_next = S_IDLE;
                    end else begin
                        w_lane_next = r_lane + LANE_W'(1);
                    end
                end
            end
            default: w_ser_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ser_state <= S_IDLE;
            r_lane      <= '0;
            r_beat      <= '0;
            r_beat_last <= 1'b0;
        end else begin
            r_ser_state <= w_ser_next;
            r_lane      <= w_lane_next;
            if (w_fifo_rd) begin
                r_beat      <= w_fifo_rdata[BEAT_W-1:0];
                r_beat_last <= w_fifo_rdata[BEAT_W];
            end
        end
    end

    always_comb begin
        w_word = r_acc;
        w_word[r_fill*DATA_WIDTH +: DATA_WIDTH] = w_lane_data;
        w_keep = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            w_keep[b] = (b < (int'(r_fill) + 1) * LANE_BYTES);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_emit) begin
                if (w_word_done) begin
                    r_acc  <= '0;
                    r_fill <= '0;
                end else begin
                    r_acc  <= w_word;
                    r_fill <= r_fill + FILL_W'(1);
                end
            end
            if (w_emit && w_word_done) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_keep  <= w_keep;
                r_out_last  <= w_flush;
            end else if (i_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Clear is applied before a same-cycle beat, so that beat starts a new count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_size       <= '0;
            r_after_last <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_overflow <= (r_overflow && !i_clear) || w_drop;
            if (w_accept) begin
                r_size       <= (i_clear || r_after_last) ? BEAT_BYTES : r_size + BEAT_BYTES;
                r_after_last <= i_last;
            end else if (i_clear) begin
                r_size       <= '0;
                r_after_last <= 1'b0;
            end
        end
    end

    always_comb begin
        w_lat_next = r_lat_state;
        case (r_lat_state)
            IDLE:    if (i_in_valid) w_lat_next = i_valid ? DONE : COUNT;
            COUNT:   if (i_valid) w_lat_next = DONE;
            DONE:    w_lat_next = DONE;
            default: w_lat_next = IDLE;
        endcase
        if (i_clear) w_lat_next = IDLE;
    end

    assign w_cnt_inc = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + LAT_WIDTH'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_lat_state <= IDLE;
        else       r_lat_state <= w_lat_next;
    end

    // The latched value includes the cycle in which the first beat arrives.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lat_cnt <= '0;
            r_latency <= '0;
        end else if (i_clear) begin
            r_latency <= '0;
        end else begin
            case (r_lat_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_lat_cnt <= '0;
                        if (i_valid) r_latency <= '0;
                    end
                end
                COUNT: begin
                    if (i_valid) r_latency <= w_cnt_inc;
                    else         r_lat_cnt <= w_cnt_inc;
                end
                default: r_lat_cnt <= r_lat_cnt;
            endcase
        end
    end

    assign o_data       = r_out_data;
    assign o_keep       = r_out_keep;
    assign o_valid      = r_out_valid;
    assign o_last       = r_out_last;
    assign o_size_bytes = r_size;
    assign o_latency    = r_latency;
    assign o_overflow   = r_overflow;
    assign o_busy       = !w_fifo_empty || (r_ser_state == S_SHIFT) || r_out_valid || (r_fill != '0);

endmodule

// File: tb/tb_task_answer_packer.sv
// Bench for task_answer_packer: default build, a 4-deep FIFO build and a 3-lane build.
module tb_task_answer_packer;

    logic clk;
    logic rst, clear, in_valid, last;

    logic [63:0] a_data;  logic a_valid, a_ready;
    logic [31:0] a_odata; logic [3:0] a_keep; logic a_ovalid, a_olast;
    logic [31:0] a_size, a_lat; logic a_ovf, a_busy;

    logic [63:0] b_data;  logic b_valid, b_ready;
    logic [31:0] b_odata; logic [3:0] b_keep; logic b_ovalid, b_olast;
    logic [31:0] b_size, b_lat; logic b_ovf, b_busy;

    logic [23:0] c_data;  logic c_valid, c_ready;
    logic [31:0] c_odata; logic [3:0] c_keep; logic c_ovalid, c_olast;
    logic [31:0] c_size, c_lat; logic c_ovf, c_busy;

    logic [36:0] a_q[$];
    logic [36:0] b_q[$];
    logic [36:0] c_q[$];
    logic [7:0]  c_pend[$];

    int n_cmp = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task_answer_packer u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_in_valid(in_valid),
        .i_data(a_data), .i_valid(a_valid), .i_last(last),
        .o_data(a_odata), .o_keep(a_keep), .o_valid(a_ovalid), .i_ready(a_ready),
        .o_last(a_olast), .o_size_bytes(a_size), .o_latency(a_lat),
        .o_overflow(a_ovf), .o_busy(a_busy)
    );

    task_answer_packer #(.FIFO_DEPTH(4)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_in_valid(in_valid),
        .i_data(b_data), .i_valid(b_valid), .i_last(last),
        .o_data(b_odata), .o_keep(b_keep), .o_valid(b_ovalid), .i_ready(b_ready),
        .o_last(b_olast), .o_size_bytes(b_size), .o_latency(b_lat),
        .o_overflow(b_ovf), .o_busy(b_busy)
    );

    task_answer_packer #(.STREAMS(3)) u_dut_c (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_in_valid(in_valid),
        .i_data(c_data), .i_valid(c_valid), .i_last(last),
        .o_data(c_odata), .o_keep(c_keep), .o_valid(c_ovalid), .i_ready(c_ready),
        .o_last(c_olast), .o_size_bytes(c_size), .o_latency(c_lat),
        .o_overflow(c_ovf), .o_busy(c_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards: each output transfer pops the oldest expected {last, keep, data}.
    logic        a_prev_stall;
    logic [36:0] a_prev_word;
    always @(negedge clk) begin
        if (rst) begin
            a_prev_stall = 1'b0;
        end else begin
            if (a_prev_stall) check("a_hold", {a_ovalid, a_olast, a_keep, a_odata}, {1'b1, a_prev_word});
            if (a_ovalid && a_ready) begin
                if (a_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL a_extra_word: got %0h with none expected", {a_olast, a_keep, a_odata});
                end else check("a_word", {a_olast, a_keep, a_odata}, a_q.pop_front());
            end
            a_prev_stall = a_ovalid && !a_ready;
            a_prev_word  = {a_olast, a_keep, a_odata};
        end
    end

    always @(negedge clk) begin
        if (!rst && b_ovalid && b_ready) begin
            if (b_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL b_extra_word: got %0h with none expected", {b_olast, b_keep, b_odata});
            end else check("b_word", {b_olast, b_keep, b_odata}, b_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && c_ovalid && c_ready) begin
            if (c_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL c_extra_word: got %0h with none expected", {c_olast, c_keep, c_odata});
            end else check("c_word", {c_olast, c_keep, c_odata}, c_q.pop_front());
        end
    end

    // Eight byte lanes always form two whole 32-bit words per beat.
    task automatic push_a(input logic [63:0] d, input logic l);
        a_q.push_back({1'b0, 4'hF, d[31:0]});
        a_q.push_back({l, 4'hF, d[63:32]});
    endtask

    // Byte-stream model for the 3-lane build: words form across beat boundaries.
    task automatic c_expect(input logic [23:0] beat, input logic l);
        logic [31:0] w;
        logic [3:0]  k;
        int          n;
        for (int i = 0; i < 3; i++) c_pend.push_back(beat[i*8 +: 8]);
        while (c_pend.size() >= 4 || (l && c_pend.size() > 0)) begin
            w = '0; k = '0;
            n = (c_pend.size() >= 4) ? 4 : c_pend.size();
            for (int j = 0; j < n; j++) begin
                w[j*8 +: 8] = c_pend.pop_front();
                k[j] = 1'b1;
            end
            c_q.push_back({l && (c_pend.size() == 0), k, w});
        end
    endtask

    task automatic drive_a(input logic [63:0] d, input logic l, input bit exp);
        if (exp) push_a(d, l);
        a_data = d; last = l; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0; last = 1'b0;
    endtask

    task automatic drive_b(input logic [63:0] d, input logic l);
        b_data = d; last = l; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0; last = 1'b0;
    endtask

    task automatic drive_c(input logic [23:0] d, input logic l, input bit exp);
        if (exp) c_expect(d, l);
        c_data = d; last = l; c_valid = 1'b1;
        @(posedge clk); #1;
        c_valid = 1'b0; last = 1'b0;
    endtask

    task automatic wait_idle(input int which, input string name);
        int  k;
        logic busy;
        for (k = 0; k < 400; k++) begin
            busy = (which == 0) ? a_busy : ((which == 1) ? b_busy : c_busy);
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (k == 400) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: still busy after 400 cycles, required idle", name);
        end
    endtask

    typedef struct {
        logic [63:0] beat;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_a_t;

    typedef struct {
        logic [23:0] beat;
        logic [31:0] w;
        logic [3:0]  keep;
    } vec_c_t;

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        vec_a_t      tbl_a[6];
        vec_c_t      tbl_c[4];
        int          k;
        logic [63:0] d;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; last = 1'b0;
        a_data = '0; a_valid = 1'b0; a_ready = 1'b1;
        b_data = '0; b_valid = 1'b0; b_ready = 1'b1;
        c_data = '0; c_valid = 1'b0; c_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_a_valid", a_ovalid, 0);
        check("rst_a_last", a_olast, 0);
        check("rst_a_keep", a_keep, 0);
        check("rst_a_size", a_size, 0);
        check("rst_a_lat", a_lat, 0);
        check("rst_a_ovf", a_ovf, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_b_valid", b_ovalid, 0);
        check("rst_c_valid", c_ovalid, 0);

        // Latency: i_in_valid at edge 0, first beat at edge 17.
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        drive_a(64'h0807060504030201, 1'b1, 1'b1);
        for (k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (a_ovalid) break;
        end
        check("first_word_latency", k, 5);
        wait_idle(0, "single_beat");
        check("single_size", a_size, 8);
        check("latency_17", a_lat, 17);
        check("single_drained", a_q.size(), 0);

        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_size", a_size, 0);
        check("clear_lat", a_lat, 0);

        // Same-cycle start and first beat; a later beat must not relatch.
        in_valid = 1'b1;
        drive_a(64'h1111_2222_3333_4444, 1'b1, 1'b1);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drive_a(64'h5555_6666_7777_8888, 1'b1, 1'b1);
        wait_idle(0, "same_cycle");
        check("same_cycle_lat", a_lat, 0);
        check("reload_after_last", a_size, 8);

        drive_a(64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1);
        check("size_reload", a_size, 8);
        clear = 1'b1;
        drive_a(64'hCAFE_F00D_89AB_CDEF, 1'b0, 1'b1);
        clear = 1'b0;
        check("clear_with_beat", a_size, 8);
        drive_a(64'h0F0E_0D0C_0B0A_0908, 1'b1, 1'b1);
        check("size_accum", a_size, 16);
        wait_idle(0, "clear_beat");

        tbl_a[0] = '{64'h0, 32'h0, 32'h0};
        tbl_a[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl_a[2] = '{64'hA5A5_5A5A_0102_8040, 32'h0102_8040, 32'hA5A5_5A5A};
        for (int i = 3; i < 6; i++) begin
            d = {$urandom, $urandom};
            tbl_a[i] = '{d, d[31:0], d[63:32]};
        end
        for (int i = 0; i < 6; i++) begin
            a_q.push_back({1'b0, 4'hF, tbl_a[i].w0});
            a_q.push_back({1'b1, 4'hF, tbl_a[i].w1});
            drive_a(tbl_a[i].beat, 1'b1, 1'b0);
            wait_idle(0, "table_a");
            check("table_a_size", a_size, 8);
        end

        // Ten back-to-back beats into a stalled output.
        a_ready = 1'b0;
        for (int i = 0; i < 10; i++) drive_a({$urandom, $urandom}, i == 9, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        check("bp_valid_held", a_ovalid, 1);
        check("bp_ovf", a_ovf, 0);
        a_ready = 1'b1;
        wait_idle(0, "backpressure");
        check("bp_drained", a_q.size(), 0);
        check("bp_size", a_size, 80);

        fork
            begin
                for (int i = 0; i < 6; i++) drive_a({$urandom, $urandom}, i == 5, 1'b1);
            end
            begin
                repeat (60) begin
                    a_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                a_ready = 1'b1;
            end
        join
        wait_idle(0, "random_ready");
        check("rr_drained", a_q.size(), 0);
        check("rr_size", a_size, 48);

        // Depth-4 FIFO: 4 beats buffered plus 1 in the serializer survive.
        b_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom};
            if (i < 5) begin
                b_q.push_back({1'b0, 4'hF, d[31:0]});
                b_q.push_back({1'b0, 4'hF, d[63:32]});
            end
            drive_b(d, i == 7);
        end
        repeat (5) @(posedge clk);
        #1;
        check("ovf_flag", b_ovf, 1);
        check("ovf_size", b_size, 40);
        check("ovf_a_clean", a_ovf, 0);
        b_ready = 1'b1;
        wait_idle(1, "overflow");
        check("ovf_drained", b_q.size(), 0);
        check("ovf_sticky", b_ovf, 1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("ovf_cleared", b_ovf, 0);
        check("ovf_size_cleared", b_size, 0);

        // Three-lane build: partial word flushes.
        tbl_c[0] = '{24'h030201, 32'h0003_0201, 4'h7};
        tbl_c[1] = '{24'hFFFFFF, 32'h00FF_FFFF, 4'h7};
        tbl_c[2] = '{24'h000000, 32'h0000_0000, 4'h7};
        tbl_c[3] = '{24'h80C0E0, 32'h0080_C0E0, 4'h7};
        for (int i = 0; i < 4; i++) begin
            c_q.push_back({1'b1, tbl_c[i].keep, tbl_c[i].w});
            drive_c(tbl_c[i].beat, 1'b1, 1'b0);
            wait_idle(2, "table_c");
            check("table_c_size", c_size, 3);
        end
        drive_c(24'h030201, 1'b0, 1'b1);
        drive_c(24'h060504, 1'b1, 1'b1);
        wait_idle(2, "c_two_beats");
        check("c_two_size", c_size, 6);
        for (int i = 0; i < 4; i++) drive_c(24'($urandom), i == 3, 1'b1);
        wait_idle(2, "c_full_last");
        check("c_full_last_size", c_size, 12);
        check("c_drained", c_q.size(), 0);

        // Reset in the middle of an answer.
        a_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive_a({$urandom, $urandom}, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_word_waiting", a_ovalid, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("abort_valid", a_ovalid, 0);
        check("abort_busy", a_busy, 0);
        check("abort_size", a_size, 0);
        a_ready = 1'b1;
        drive_a(64'h1122_3344_5566_7788, 1'b1, 1'b1);
        wait_idle(0, "after_abort");
        check("after_abort_size", a_size, 8);
        check("after_abort_drained", a_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
